z80fi_retire_monitor: RTL and testbench

Producer side of the z80fi formal interface. Sits inside the core and watches per-M-cycle trace events: opcode/operand fetches, register-file reads and writes, memory accesses and PC. It assembles them into one retirement record per instruction. It presents that record on the `z80fi_*` bus as a single-cycle `z80fi_valid` pulse, which is what every `z80fi_insn_spec_*` checker consumes.

---
 rtl/z80fi_retire_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_z80fi_retire_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/z80fi_retire_monitor.sv
// Producer side of the z80fi formal interface: folds per-M-cycle trace events into one
// retirement record per instruction. Build option Z80FI_MEM2_EN enables the second memory slots.
module z80fi_retire_monitor #(
    parameter int MAX_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tr_start,
    input  logic [15:0]          tr_pc,
    input  logic                 tr_done,
    input  logic [15:0]          tr_pc_next,
    input  logic                 tr_fetch,
    input  logic [7:0]           tr_fetch_data,
    input  logic                 tr_reg_rd,
    input  logic [2:0]           tr_reg_rnum,
    input  logic [15:0]          tr_reg_rdata,
    input  logic                 tr_reg_wr,
    input  logic [2:0]           tr_reg_wnum,
    input  logic [15:0]          tr_reg_wdata,
    input  logic                 tr_mem_rd,
    input  logic [15:0]          tr_mem_rd_addr,
    input  logic [7:0]           tr_mem_rd_data,
    input  logic                 tr_mem_wr,
    input  logic [15:0]          tr_mem_wr_addr,
    input  logic [7:0]           tr_mem_wr_data,
    output logic                 z80fi_valid,
    output logic [8*MAX_LEN-1:0] z80fi_insn,
    output logic [2:0]           z80fi_insn_len,
    output logic [15:0]          z80fi_pc_rdata,
    output logic [15:0]          z80fi_pc_wdata,
    output logic                 z80fi_reg1_rd,
    output logic [2:0]           z80fi_reg1_rnum,
    output logic [15:0]          z80fi_reg1_rdata,
    output logic                 z80fi_reg2_rd,
    output logic [2:0]           z80fi_reg2_rnum,
    output logic [15:0]          z80fi_reg2_rdata,
    output logic                 z80fi_reg_wr,
    output logic [2:0]           z80fi_reg_wnum,
    output logic [15:0]          z80fi_reg_wdata,
    output logic                 z80fi_mem_rd,
    output logic [15:0]          z80fi_mem_raddr,
    output logic [7:0]           z80fi_mem_rdata,
    output logic                 z80fi_mem_rd2,
    output logic [15:0]          z80fi_mem_raddr2,
    output logic [7:0]           z80fi_mem_rdata2,
    output logic                 z80fi_mem_wr,
    output logic [15:0]          z80fi_mem_waddr,
    output logic [7:0]           z80fi_mem_wdata,
    output logic                 z80fi_mem_wr2,
    output logic [15:0]          z80fi_mem_waddr2,
    output logic [7:0]           z80fi_mem_wdata2
);

`ifdef Z80FI_MEM2_EN
    localparam bit MEM2 = 1'b1;
`else
    localparam bit MEM2 = 1'b0;
`endif

    typedef enum logic {IDLE, COLLECT} state_t;

    typedef struct packed {
        logic [8*MAX_LEN-1:0] insn;
        logic [2:0]           len;
        logic [15:0]          pc_rdata;
        logic [15:0]          pc_wdata;
        logic                 reg1_rd;
        logic [2:0]           reg1_rnum;
        logic [15:0]          reg1_rdata;
        logic                 reg2_rd;
        logic [2:0]           reg2_rnum;
        logic [15:0]          reg2_rdata;
        logic                 reg_wr;
        logic [2:0]           reg_wnum;
        logic [15:0]          reg_wdata;
        logic                 mem_rd;
        logic [15:0]          mem_raddr;
        logic [7:0]           mem_rdata;
        logic                 mem_rd2;
        logic [15:0]          mem_raddr2;
        logic [7:0]           mem_rdata2;
        logic                 mem_wr;
        logic [15:0]          mem_waddr;
        logic [7:0]           mem_wdata;
        logic                 mem_wr2;
        logic [15:0]          mem_waddr2;
        logic [7:0]           mem_wdata2;
    } rec_t;

    state_t state, state_nxt;
    rec_t   acc, seed, evt, rec_nxt, rec_p1;
    logic   retire, vld_p1;

    always_comb begin
        seed = acc;
        if (tr_start) begin
            seed          = '0;
            seed.pc_rdata = tr_pc;
        end

        // Events land in the record that is open after any tr_start this cycle.
        evt = seed;
        if (tr_start || state == COLLECT) begin
            if (tr_fetch && evt.len < 3'(MAX_LEN)) begin
                for (int k = 0; k < MAX_LEN; k++) begin
                    if (evt.len == 3'(k)) evt.insn[8*k +: 8] = tr_fetch_data;
                end
                evt.len = evt.len + 3'd1;
            end
            if (tr_reg_rd) begin
                if (!evt.reg1_rd) begin
                    evt.reg1_rd    = 1'b1;
                    evt.reg1_rnum  = tr_reg_rnum;
                    evt.reg1_rdata = tr_reg_rdata;
                end else if (!evt.reg2_rd) begin
                    evt.reg2_rd    = 1'b1;
                    evt.reg2_rnum  = tr_reg_rnum;
                    evt.reg2_rdata = tr_reg_rdata;
                end
            end
            if (tr_reg_wr) begin
                evt.reg_wr    = 1'b1;
                evt.reg_wnum  = tr_reg_wnum;
                evt.reg_wdata = tr_reg_wdata;
            end
            if (tr_mem_rd) begin
                if (!evt.mem_rd) begin
                    evt.mem_rd    = 1'b1;
                    evt.mem_raddr = tr_mem_rd_addr;
                    evt.mem_rdata = tr_mem_rd_data;
                end else if (MEM2 && !evt.mem_rd2) begin
                    evt.mem_rd2    = 1'b1;
                    evt.mem_raddr2 = tr_mem_rd_addr;
                    evt.mem_rdata2 = tr_mem_rd_data;
                end
            end
            if (tr_mem_wr) begin
                if (!evt.mem_wr) begin
                    evt.mem_wr    = 1'b1;
                    evt.mem_waddr = tr_mem_wr_addr;
                    evt.mem_wdata = tr_mem_wr_data;
                end else if (MEM2 && !evt.mem_wr2) begin
                    evt.mem_wr2    = 1'b1;
                    evt.mem_waddr2 = tr_mem_wr_addr;
                    evt.mem_wdata2 = tr_mem_wr_data;
                end
            end
        end

        // From IDLE a start+done cycle is a whole one-cycle instruction; from COLLECT it
        // retires the open record and this cycle's events belong to the next one.
        retire    = 1'b0;
        rec_nxt   = evt;
        state_nxt = state;
        if (state == COLLECT) begin
            if (tr_done) begin
                retire = 1'b1;
                if (tr_start) rec_nxt = acc;
                else          state_nxt = IDLE;
            end
        end else if (tr_start) begin
            if (tr_done) retire = 1'b1;
            else         state_nxt = COLLECT;
        end
        rec_nxt.pc_wdata = tr_pc_next;
    end

    // Record register: p1 holds the last retired instruction until the next retirement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            acc    <= '0;
            rec_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= evt;
            vld_p1 <= retire;
            if (retire) rec_p1 <= rec_nxt;
        end
    end

    assign z80fi_valid      = vld_p1;
    assign z80fi_insn       = rec_p1.insn;
    assign z80fi_insn_len   = rec_p1.len;
    assign z80fi_pc_rdata   = rec_p1.pc_rdata;
    assign z80fi_pc_wdata   = rec_p1.pc_wdata;
    assign z80fi_reg1_rd    = rec_p1.reg1_rd;
    assign z80fi_reg1_rnum  = rec_p1.reg1_rnum;
    assign z80fi_reg1_rdata = rec_p1.reg1_rdata;
    assign z80fi_reg2_rd    = rec_p1.reg2_rd;
    assign z80fi_reg2_rnum  = rec_p1.reg2_rnum;
    assign z80fi_reg2_rdata = rec_p1.reg2_rdata;
    assign z80fi_reg_wr     = rec_p1.reg_wr;
    assign z80fi_reg_wnum   = rec_p1.reg_wnum;
    assign z80fi_reg_wdata  = rec_p1.reg_wdata;
    assign z80fi_mem_rd     = rec_p1.mem_rd;
    assign z80fi_mem_raddr  = rec_p1.mem_raddr;
    assign z80fi_mem_rdata  = rec_p1.mem_rdata;
    assign z80fi_mem_rd2    = rec_p1.mem_rd2;
    assign z80fi_mem_raddr2 = rec_p1.mem_raddr2;
    assign z80fi_mem_rdata2 = rec_p1.mem_rdata2;
    assign z80fi_mem_wr     = rec_p1.mem_wr;
    assign z80fi_mem_waddr  = rec_p1.mem_waddr;
    assign z80fi_mem_wdata  = rec_p1.mem_wdata;
    assign z80fi_mem_wr2    = rec_p1.mem_wr2;
    assign z80fi_mem_waddr2 = rec_p1.mem_waddr2;
    assign z80fi_mem_wdata2 = rec_p1.mem_wdata2;

endmodule

// File: tb/tb_z80fi_retire_monitor.sv
// Directed bench for z80fi_retire_monitor: hand-computed retirement records.
module tb_z80fi_retire_monitor;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        tr_start, tr_done, tr_fetch, tr_reg_rd, tr_reg_wr, tr_mem_rd, tr_mem_wr;
    logic [15:0] tr_pc, tr_pc_next, tr_reg_rdata, tr_reg_wdata, tr_mem_rd_addr, tr_mem_wr_addr;
    logic [7:0]  tr_fetch_data, tr_mem_rd_data, tr_mem_wr_data;
    logic [2:0]  tr_reg_rnum, tr_reg_wnum;

    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len, z80fi_reg1_rnum, z80fi_reg2_rnum, z80fi_reg_wnum;
    logic [15:0] z80fi_pc_rdata, z80fi_pc_wdata, z80fi_reg1_rdata, z80fi_reg2_rdata, z80fi_reg_wdata;
    logic        z80fi_reg1_rd, z80fi_reg2_rd, z80fi_reg_wr;
    logic        z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr, z80fi_mem_wr2;
    logic [15:0] z80fi_mem_raddr, z80fi_mem_raddr2, z80fi_mem_waddr, z80fi_mem_waddr2;
    logic [7:0]  z80fi_mem_rdata, z80fi_mem_rdata2, z80fi_mem_wdata, z80fi_mem_wdata2;

    int n_checks = 0;
    int n_errors = 0;

    z80fi_retire_monitor #(.MAX_LEN(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .tr_start(tr_start), .tr_pc(tr_pc), .tr_done(tr_done), .tr_pc_next(tr_pc_next),
        .tr_fetch(tr_fetch), .tr_fetch_data(tr_fetch_data),
        .tr_reg_rd(tr_reg_rd), .tr_reg_rnum(tr_reg_rnum), .tr_reg_rdata(tr_reg_rdata),
        .tr_reg_wr(tr_reg_wr), .tr_reg_wnum(tr_reg_wnum), .tr_reg_wdata(tr_reg_wdata),
        .tr_mem_rd(tr_mem_rd), .tr_mem_rd_addr(tr_mem_rd_addr), .tr_mem_rd_data(tr_mem_rd_data),
        .tr_mem_wr(tr_mem_wr), .tr_mem_wr_addr(tr_mem_wr_addr), .tr_mem_wr_data(tr_mem_wr_data),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_pc_rdata(z80fi_pc_rdata), .z80fi_pc_wdata(z80fi_pc_wdata),
        .z80fi_reg1_rd(z80fi_reg1_rd), .z80fi_reg1_rnum(z80fi_reg1_rnum), .z80fi_reg1_rdata(z80fi_reg1_rdata),
        .z80fi_reg2_rd(z80fi_reg2_rd), .z80fi_reg2_rnum(z80fi_reg2_rnum), .z80fi_reg2_rdata(z80fi_reg2_rdata),
        .z80fi_reg_wr(z80fi_reg_wr), .z80fi_reg_wnum(z80fi_reg_wnum), .z80fi_reg_wdata(z80fi_reg_wdata),
        .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_rdata(z80fi_mem_rdata),
        .z80fi_mem_rd2(z80fi_mem_rd2), .z80fi_mem_raddr2(z80fi_mem_raddr2), .z80fi_mem_rdata2(z80fi_mem_rdata2),
        .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
        .z80fi_mem_wr2(z80fi_mem_wr2), .z80fi_mem_waddr2(z80fi_mem_waddr2), .z80fi_mem_wdata2(z80fi_mem_wdata2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        tr_start = 0; tr_done = 0; tr_fetch = 0; tr_reg_rd = 0; tr_reg_wr = 0;
        tr_mem_rd = 0; tr_mem_wr = 0;
        tr_pc = 0; tr_pc_next = 0; tr_fetch_data = 0;
        tr_reg_rnum = 0; tr_reg_rdata = 0; tr_reg_wnum = 0; tr_reg_wdata = 0;
        tr_mem_rd_addr = 0; tr_mem_rd_data = 0; tr_mem_wr_addr = 0; tr_mem_wr_data = 0;
    endtask

    // Commit the inputs set up for this cycle, then look at the registered outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic fetch(input logic [7:0] b);
        tr_fetch = 1; tr_fetch_data = b;
    endtask

    task automatic start(input logic [15:0] pc);
        tr_start = 1; tr_pc = pc;
    endtask

    task automatic done(input logic [15:0] pcn);
        tr_done = 1; tr_pc_next = pcn;
    endtask

    initial begin
        clr();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, z80fi_valid}, 32'd0);
        chk("rst_insn", z80fi_insn, 32'd0);
        chk("rst_pc", {16'd0, z80fi_pc_rdata}, 32'd0);
        reset_n = 1;
        tick();

        // LD B,C over three cycles
        start(16'h1000); fetch(8'h41); tick();
        chk("ldbc_nopulse", {31'd0, z80fi_valid}, 32'd0);
        tr_reg_rd = 1; tr_reg_rnum = 3'd1; tr_reg_rdata = 16'h005A; tick();
        tr_reg_wr = 1; tr_reg_wnum = 3'd0; tr_reg_wdata = 16'h005A; done(16'h1001); tick();
        chk("ldbc_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("ldbc_insn", z80fi_insn, 32'h00000041);
        chk("ldbc_len", {29'd0, z80fi_insn_len}, 32'd1);
        chk("ldbc_reg1", {z80fi_reg1_rd, z80fi_reg1_rnum, z80fi_reg1_rdata}, {1'b1, 3'd1, 16'h005A});
        chk("ldbc_reg2_rd", {31'd0, z80fi_reg2_rd}, 32'd0);
        chk("ldbc_regw", {z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata}, {1'b1, 3'd0, 16'h005A});
        chk("ldbc_pc", {z80fi_pc_rdata, z80fi_pc_wdata}, 32'h10001001);
        chk("ldbc_mem", {28'd0, z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr, z80fi_mem_wr2}, 32'd0);
        tick();
        chk("hold_valid", {31'd0, z80fi_valid}, 32'd0);
        chk("hold_insn", z80fi_insn, 32'h00000041);

        // Five fetches: byte 5 dropped, length saturates
        start(16'h1100); fetch(8'hDD); tick();
        fetch(8'hCB); tick();
        fetch(8'h05); tick();
        fetch(8'h06); tick();
        fetch(8'hFF); done(16'h1104); tick();
        chk("long_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("long_insn", z80fi_insn, 32'h0605CBDD);
        chk("long_len", {29'd0, z80fi_insn_len}, 32'd4);

        // Back-to-back: the overlap cycle's fetch belongs to the second record
        start(16'h2000); fetch(8'h00); tr_reg_rd = 1; tr_reg_rnum = 3'd2; tr_reg_rdata = 16'h0077; tick();
        done(16'h2001); start(16'h2001); fetch(8'h3C); tick();
        chk("b2b1_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("b2b1_pc", {z80fi_pc_rdata, z80fi_pc_wdata}, 32'h20002001);
        chk("b2b1_insn", z80fi_insn, 32'h00000000);
        chk("b2b1_len", {29'd0, z80fi_insn_len}, 32'd1);
        chk("b2b1_reg1", {z80fi_reg1_rd, z80fi_reg1_rnum, z80fi_reg1_rdata}, {1'b1, 3'd2, 16'h0077});
        done(16'h2002); tick();
        chk("b2b2_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("b2b2_pc", {z80fi_pc_rdata, z80fi_pc_wdata}, 32'h20012002);
        chk("b2b2_insn", z80fi_insn, 32'h0000003C);
        chk("b2b2_regs", {29'd0, z80fi_reg1_rd, z80fi_reg2_rd, z80fi_reg_wr}, 32'd0);
        tick();
        chk("b2b_end", {31'd0, z80fi_valid}, 32'd0);

        // Restart without done discards the partial record
        start(16'h6000); fetch(8'hAA); tick();
        start(16'h6100); fetch(8'hBB); tick();
        chk("restart_nopulse", {31'd0, z80fi_valid}, 32'd0);
        done(16'h6101); tick();
        chk("restart_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("restart_pc", {16'd0, z80fi_pc_rdata}, 32'h6100);
        chk("restart_insn", z80fi_insn, 32'h000000BB);

        // Done while idle is ignored
        done(16'h9999); tick();
        chk("idle_done", {31'd0, z80fi_valid}, 32'd0);

        // Minimum one-cycle instruction from IDLE
        start(16'h7000); fetch(8'h00); done(16'h7001); tick();
        chk("min_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("min_len", {29'd0, z80fi_insn_len}, 32'd1);
        chk("min_pc", {z80fi_pc_rdata, z80fi_pc_wdata}, 32'h70007001);
        tick();

        // Three reads, two writes
        start(16'h4000); fetch(8'hED); tr_reg_rd = 1; tr_reg_rnum = 3'd1; tr_reg_rdata = 16'h0011; tick();
        tr_reg_rd = 1; tr_reg_rnum = 3'd2; tr_reg_rdata = 16'h0022;
        tr_reg_wr = 1; tr_reg_wnum = 3'd4; tr_reg_wdata = 16'h1111; tick();
        tr_reg_rd = 1; tr_reg_rnum = 3'd3; tr_reg_rdata = 16'h0033;
        tr_reg_wr = 1; tr_reg_wnum = 3'd5; tr_reg_wdata = 16'h2222; done(16'h4002); tick();
        chk("r3_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("r3_reg1", {z80fi_reg1_rd, z80fi_reg1_rnum, z80fi_reg1_rdata}, {1'b1, 3'd1, 16'h0011});
        chk("r3_reg2", {z80fi_reg2_rd, z80fi_reg2_rnum, z80fi_reg2_rdata}, {1'b1, 3'd2, 16'h0022});
        chk("r3_regw", {z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata}, {1'b1, 3'd5, 16'h2222});
        tick();

        // Two memory reads and two writes
        start(16'h5000); fetch(8'h7E); tick();
        tr_mem_rd = 1; tr_mem_rd_addr = 16'h3000; tr_mem_rd_data = 8'h11;
        tr_mem_wr = 1; tr_mem_wr_addr = 16'h5000; tr_mem_wr_data = 8'h33; tick();
        tr_mem_rd = 1; tr_mem_rd_addr = 16'h3001; tr_mem_rd_data = 8'h22;
        tr_mem_wr = 1; tr_mem_wr_addr = 16'h5001; tr_mem_wr_data = 8'h44; done(16'h5001); tick();
        chk("mem_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("mem_rd", {z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata}, {1'b1, 16'h3000, 8'h11});
        chk("mem_wr", {z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata}, {1'b1, 16'h5000, 8'h33});
`ifdef Z80FI_MEM2_EN
        chk("mem_rd2", {z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2}, {1'b1, 16'h3001, 8'h22});
        chk("mem_wr2", {z80fi_mem_wr2, z80fi_mem_waddr2, z80fi_mem_wdata2}, {1'b1, 16'h5001, 8'h44});
`else
        chk("mem_rd2", {z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2}, 32'd0);
        chk("mem_wr2", {z80fi_mem_wr2, z80fi_mem_waddr2, z80fi_mem_wdata2}, 32'd0);
`endif
        tick();

        // Async reset mid-collection after two fetches
        start(16'h8000); fetch(8'h12); tick();
        fetch(8'h34); tick();
        #2 reset_n = 0;
        #1;
        chk("arst_valid", {31'd0, z80fi_valid}, 32'd0);
        chk("arst_insn", z80fi_insn, 32'd0);
        chk("arst_pc", {z80fi_pc_rdata, z80fi_pc_wdata}, 32'd0);
        chk("arst_mem", {z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1;
        done(16'h8002); tick();
        chk("arst_nopulse", {31'd0, z80fi_valid}, 32'd0);
        tick();
        chk("arst_still0", {31'd0, z80fi_valid}, 32'd0);
        start(16'h8100); fetch(8'h56); tick();
        done(16'h8101); tick();
        chk("arst_fresh_valid", {31'd0, z80fi_valid}, 32'd1);
        chk("arst_fresh_insn", z80fi_insn, 32'h00000056);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
